// File: rtl/ref_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ref_scheduler
//  Description : Per-bank DDR4 refresh scheduler. Issues REF commands
//                round-robin over all banks (ba inner, bg outer), postpones
//                them while the host is busy, forces them by stalling the
//                host once the postponement allowance is used up, and tracks
//                the per-bank tRFC blackout window.
//  Config      : REF_POSTPONE_EN - when defined, up to MAXPEND refreshes may
//                be owed; when undefined, the allowance is one refresh and
//                every tick immediately forces a refresh.
//  Revision    : 1.0 - initial release
// ============================================================================
module ref_scheduler #(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int TREFI_PB  = 10400,
    parameter int TRFC_PB   = 4,
    parameter int MAXPEND   = 8
) (
    input  logic                                ck_t,
    input  logic                                reset,
    input  logic                                host_valid,
    output logic                                host_ready,
    input  logic [RANKS-1:0]                    host_cs_n,
    input  logic                                host_act_n,
    input  logic [ADDRWIDTH-1:0]                host_A,
    input  logic [BGWIDTH-1:0]                  host_bg,
    input  logic [BAWIDTH-1:0]                  host_ba,
    input  logic [2**(BGWIDTH+BAWIDTH)-1:0]     bank_busy,
    output logic [RANKS-1:0]                    cs_n,
    output logic                                act_n,
    output logic [ADDRWIDTH-1:0]                A,
    output logic [BGWIDTH-1:0]                  bg,
    output logic [BAWIDTH-1:0]                  ba,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]     bank_blocked,
    output logic [3:0]                          ref_pending,
    output logic                                ref_overflow
);

    localparam int c_ptr_w  = BGWIDTH + BAWIDTH;
    localparam int c_nbanks = 2 ** c_ptr_w;
    localparam int c_cnt_w  = $clog2(TREFI_PB);
    localparam int c_rfc_w  = $clog2(TRFC_PB + 1);

    localparam logic [c_cnt_w-1:0]   c_trefi_reload = c_cnt_w'(TREFI_PB - 1);
    localparam logic [c_rfc_w-1:0]   c_trfc_load    = c_rfc_w'(TRFC_PB);
    // A[16:14]=001 selects REF, A[0]=1 selects the per-bank variant
    localparam logic [ADDRWIDTH-1:0] c_ref_addr     = ADDRWIDTH'(17'h04001);

`ifdef REF_POSTPONE_EN
    localparam logic [3:0] c_max_pend = 4'(MAXPEND);
`else
    // Without postponement at most one refresh may be owed at a time
    localparam logic [3:0] c_max_pend = (MAXPEND > 1) ? 4'd1 : 4'(MAXPEND);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_interval;
    logic [c_ptr_w-1:0]   r_ptr;
    logic                 w_tick;
    logic                 w_issue;
    logic                 w_drop;
    logic [3:0]           w_pending_nxt;

    // Refresh decision: tick detection, issue condition and owed-count update
    always_comb begin
        w_tick        = (r_interval == '0);
        w_issue       = (ref_pending != 4'd0) && !bank_busy[r_ptr] &&
                        !bank_blocked[r_ptr] &&
                        (!host_valid || (r_state == S_FORCE));
        // A tick is only lost when the allowance is full and nothing drains it
        w_drop        = w_tick && !w_issue && (ref_pending == c_max_pend);
        w_pending_nxt = ref_pending;
        if (w_tick && !w_issue && !w_drop) begin
            w_pending_nxt = ref_pending + 4'd1;
        end else if (w_issue && !w_tick) begin
            w_pending_nxt = ref_pending - 4'd1;
        end
        if (w_pending_nxt == 4'd0) begin
            w_state_nxt = S_IDLE;
        end else if (w_pending_nxt == c_max_pend) begin
            w_state_nxt = S_FORCE;
        end else begin
            w_state_nxt = S_PEND;
        end
    end

    // The host is stalled while a refresh is forced or takes the bus
    assign host_ready = !reset && (r_state != S_FORCE) && !w_issue;

    // Scheduler FSM: interval counter, owed count, overflow flag, bank pointer
    always_ff @(posedge ck_t) begin
        if (reset) begin
            r_interval   <= c_trefi_reload;
            ref_pending  <= 4'd0;
            r_state      <= S_IDLE;
            ref_overflow <= 1'b0;
            r_ptr        <= '0;
        end else begin
            r_interval   <= w_tick ? c_trefi_reload : (r_interval - c_cnt_w'(1));
            ref_pending  <= w_pending_nxt;
            r_state      <= w_state_nxt;
            if (w_drop) begin
                ref_overflow <= 1'b1;
            end
            if (w_issue) begin
                r_ptr <= r_ptr + c_ptr_w'(1);
            end
        end
    end

    // DIMM command bus: REF has priority, then the host, otherwise deselect
    always_ff @(posedge ck_t) begin
        if (reset) begin
            cs_n  <= '1;
            act_n <= 1'b1;
            A     <= '0;
            bg    <= '0;
            ba    <= '0;
        end else if (w_issue) begin
            cs_n  <= '0;
            act_n <= 1'b1;
            A     <= c_ref_addr;
            bg    <= r_ptr[c_ptr_w-1:BAWIDTH];
            ba    <= r_ptr[BAWIDTH-1:0];
        end else if (host_valid && host_ready) begin
            cs_n  <= host_cs_n;
            act_n <= host_act_n;
            A     <= host_A;
            bg    <= host_bg;
            ba    <= host_ba;
        end else begin
            cs_n  <= '1;
            act_n <= 1'b1;
            A     <= '0;
            bg    <= '0;
            ba    <= '0;
        end
    end

    // Per-bank tRFC window; the counter is loaded in the same edge the REF
    // reaches the bus, so the bank reads blocked for exactly TRFC_PB cycles
    for (genvar gi = 0; gi < c_nbanks; gi++) begin : g_bank
        logic [c_rfc_w-1:0] r_rfc_cnt;

        // Load on REF to this bank, otherwise count down to zero
        always_ff @(posedge ck_t) begin
            if (reset) begin
                r_rfc_cnt <= '0;
            end else if (w_issue && (r_ptr == c_ptr_w'(gi))) begin
                r_rfc_cnt <= c_trfc_load;
            end else if (r_rfc_cnt != '0) begin
                r_rfc_cnt <= r_rfc_cnt - c_rfc_w'(1);
            end
        end

        assign bank_blocked[gi] = (r_rfc_cnt != '0);
    end

endmodule
`default_nettype wire
